multiport_regfile: RTL and testbench
====================================

// Module: multiport_regfile
// PURPOSE
//  Parametrised successor to the single-write, dual-read pipeline register file.
//  Provides N registered read ports, one write port and write-to-read bypass.
//  After reset it runs a hardware clear sweep so that every register holds zero.
//  Sits in the ID stage of the pipelined MIPS core. It feeds the ID/EX operand
//  latches and is written from the WB stage.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W   5  address width; DEPTH = 2**ADDR_W registers
//  NRD      2  number of read ports (1..4)
// PORTS
//  clock    in   1             single clock, rising edge
//  reset    in   1             synchronous, active-high
//  wen      in   1             write enable (WB stage)
//  wr_addr  in   ADDR_W        write address
//  wr_data  in   DATA_W        write data
//  rd_addr  in   NRD*ADDR_W    read addresses; port k = [k*ADDR_W +: ADDR_W]
//  rd_data  out  NRD*DATA_W    read data, registered; port k = [k*DATA_W +: DATA_W]
//  ready    out  1             1 = clear sweep complete; writes are accepted
// BEHAVIOUR
//  - Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
//  - Reset values: rd_data = 0 on all ports, ready = 0, FSM = CLEAR, clr_cnt = 0.
//  - FSM states: CLEAR and RUN.
//    - In reset: state goes to CLEAR.
//    - CLEAR: writes mem[clr_cnt] <= 0, then clr_cnt++.
//    - CLEAR -> RUN when clr_cnt == DEPTH-1 has been written, so CLEAR lasts DEPTH cycles.
//    - clr_cnt is ADDR_W bits wide and wraps to 0 on entry to RUN.
//    - ready = (state == RUN), driven from a register. No glitch on the transition.
//  - Reset mid-sweep or in RUN: the sweep restarts at address 0. Register contents are
//    not guaranteed until ready = 1.
//  - Write: in RUN, wen = 1 writes mem[wr_addr] <= wr_data at the rising edge.
//    In CLEAR, wen is ignored and the data is dropped. Issuing writes in CLEAR is a
//    protocol error.
//  - Read latency is 1 cycle: rd_data[k] at edge t+1 = value of mem[rd_addr[k]] sampled at edge t.
//  - Bypass (write-first): if wen && ready && wr_addr == rd_addr[k] in the same cycle,
//    rd_data[k] <= wr_data. Every port bypasses independently.
//  - In CLEAR, all rd_data ports load 0.
//  - All ports may read the same address at the same time. No arbitration is needed.
// CONFIGURATION
//  - Macro: `MULTIPORT_REGFILE_ZERO_REG_EN`. Governs register 0; all other behaviour is unchanged.
//  - Defined: register 0 is hardwired to zero, as MIPS $zero.
//    - Writes to address 0 are discarded.
//    - Reads of address 0 return 0 and never take the bypass path.
//  - Undefined: register 0 is an ordinary register.
// STRUCTURE
//  - Shared constants go in constants.h: RF_DATA_W, RF_ADDR_W and the state encodings
//    RF_ST_CLEAR = 1'b0, RF_ST_RUN = 1'b1.
//  - Sub-module regfile_clear_fsm(clock, reset, clr_we, clr_addr, ready) holds the state
//    register and clr_cnt.
//  - The top level owns the memory array, the write mux (clear vs WB) and the per-port
//    read and bypass logic. Per-port logic is built with a generate loop over NRD.
// TESTING
//  1. Reset for 1 cycle, release:
//     - ready is 0 for exactly 32 cycles, then 1.
//     - Reads of addresses 0..31 all return 0.
//  2. In RUN, write reg 5 = 32'hDEADBEEF with rd_addr port 0 = 5 in the same cycle:
//     port 0 shows DEADBEEF on the next edge (bypass).
//  3. NRD = 4, all ports read address 7 after writing 32'h0000_1234:
//     all four ports return 0000_1234 with 1-cycle latency.
//  4. Assert wen to address 3 with 32'hFFFF_FFFF while ready = 0:
//     after ready rises, reading address 3 returns 0.
//  5. Write reg 9 = 42, then pulse reset 10 cycles into RUN:
//     - ready drops.
//     - The sweep restarts from 0 and lasts 32 cycles.
//     - Reg 9 reads 0 afterwards.
//  6. With ZERO_REG_EN: write 32'hA5A5A5A5 to reg 0 and read it in the same and the
//     next cycle: both reads return 0. Without the macro, A5A5A5A5 is returned (bypass, then array).

Source files
------------

// File: rtl/multiport_regfile_pkg.sv
// Shared constants and the clear-sweep state encoding for the multiport register file.
package multiport_regfile_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   typedef enum logic {
      RF_ST_CLEAR = 1'b0,
      RF_ST_RUN   = 1'b1
   } rfState_t;

endpackage

// File: rtl/multiport_regfile_clear_fsm.sv
// Clear-sweep controller for the multiport register file.
// Holds the CLEAR/RUN state and the sweep counter. After reset it walks addresses
// 0..DEPTH-1 once, then raises ready from a register.
import multiport_regfile_pkg::*;

module regfile_clear_fsm #(
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);

   rfState_t          r_state;
   rfState_t          w_nextState;
   logic [ADDR_W-1:0] r_clrCnt;
   logic [ADDR_W-1:0] w_nextCnt;
   logic              r_ready;

   // Next-state and counter logic: count through every address, leave CLEAR after the last one
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_clrCnt;
      case (r_state)
         RF_ST_CLEAR: begin
            w_nextCnt = r_clrCnt + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (r_clrCnt == {ADDR_W{1'b1}}) begin
               w_nextState = RF_ST_RUN;
            end
         end
         RF_ST_RUN: begin
            w_nextCnt = '0;
         end
         default: begin
            w_nextState = RF_ST_CLEAR;
            w_nextCnt   = '0;
         end
      endcase
   end

   // State, counter and registered ready; ready tracks the state being entered so it never glitches
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= RF_ST_CLEAR;
         r_clrCnt <= '0;
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_clrCnt <= w_nextCnt;
         r_ready  <= (w_nextState == RF_ST_RUN);
      end
   end

   assign clr_we   = (r_state == RF_ST_CLEAR) && !reset;
   assign clr_addr = r_clrCnt;
   assign ready    = r_ready;

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file: NRD registered read ports, one write port, write-first bypass,
// and a hardware clear sweep after reset.
// Optional build macro MULTIPORT_REGFILE_ZERO_REG_EN hardwires register 0 to zero
// (writes to it are dropped, reads of it return 0 without bypass).
import multiport_regfile_pkg::*;

module multiport_regfile #(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NRD    = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wen,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic                  ready
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_clrWe;
   logic [ADDR_W-1:0] w_clrAddr;
   logic              w_ready;
   logic              w_wbWe;
   logic              w_memWe;
   logic [ADDR_W-1:0] w_memAddr;
   logic [DATA_W-1:0] w_memData;

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clearFsm (
      .clock    (clock),
      .reset    (reset),
      .clr_we   (w_clrWe),
      .clr_addr (w_clrAddr),
      .ready    (w_ready)
   );

   assign ready = w_ready;

`ifdef MULTIPORT_REGFILE_ZERO_REG_EN
   assign w_wbWe = wen && w_ready && (wr_addr != '0);
`else
   assign w_wbWe = wen && w_ready;
`endif

   // Write port mux: the clear sweep owns the array until ready, then the WB stage does
   always_comb begin
      w_memWe   = 1'b0;
      w_memAddr = wr_addr;
      w_memData = wr_data;
      if (w_clrWe) begin
         w_memWe   = 1'b1;
         w_memAddr = w_clrAddr;
         w_memData = '0;
      end else if (w_wbWe) begin
         w_memWe = 1'b1;
      end
   end

   // Storage array; no reset because the sweep zeroes it after every reset
   always_ff @(posedge clock) begin
      if (w_memWe) begin
         r_mem[w_memAddr] <= w_memData;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_port
      logic [ADDR_W-1:0] w_rdAddr;
      logic              w_bypass;
      logic              w_zeroRead;
      logic [DATA_W-1:0] r_rdPort;

      assign w_rdAddr = rd_addr[k*ADDR_W +: ADDR_W];
      assign w_bypass = w_wbWe && (wr_addr == w_rdAddr);

`ifdef MULTIPORT_REGFILE_ZERO_REG_EN
      assign w_zeroRead = (w_rdAddr == '0);
`else
      assign w_zeroRead = 1'b0;
`endif

      // Registered read with write-first bypass; forced to zero while the sweep runs
      always_ff @(posedge clock) begin
         if (reset || !w_ready || w_zeroRead) begin
            r_rdPort <= '0;
         end else if (w_bypass) begin
            r_rdPort <= wr_data;
         end else begin
            r_rdPort <= r_mem[w_rdAddr];
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = r_rdPort;
   end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile built with four read ports.
// Honours MULTIPORT_REGFILE_ZERO_REG_EN when it is defined for the build.
module tb_multiport_regfile;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 4;

   logic             clock;
   logic             reset;
   logic             wen;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic             ready;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          wen;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [AW-1:0] ra  [NRD];
      logic [DW-1:0] exp [NRD];
   } vec_t;

   vec_t vecs [9];

   multiport_regfile #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .NRD    (NRD)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .wen     (wen),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .ready   (ready)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then move to 1 ns after the capturing edge
   task automatic applyStimulus(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      wen     = w;
      wr_addr = wa;
      wr_data = wd;
      rd_addr = {a3, a2, a1, a0};
      @(posedge clock);
      #1;
   endtask

   task automatic addVec(input int idx, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
      vecs[idx].wen    = w;
      vecs[idx].wa     = wa;
      vecs[idx].wd     = wd;
      vecs[idx].ra[0]  = a0;
      vecs[idx].ra[1]  = a1;
      vecs[idx].ra[2]  = a2;
      vecs[idx].ra[3]  = a3;
      vecs[idx].exp[0] = e0;
      vecs[idx].exp[1] = e1;
      vecs[idx].exp[2] = e2;
      vecs[idx].exp[3] = e3;
   endtask

   // One-cycle reset pulse, then count cycles until ready rises (bounded)
   task automatic resetAndSweep(input string tag, input logic w, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd);
      int cycles;
      reset = 1'b1;
      applyStimulus(w, wa, wd, wa, wa, wa, wa);
      reset = 1'b0;
      checkOutput({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
      cycles = 0;
      while (!ready && cycles < 40) begin
         applyStimulus(w, wa, wd, wa, wa, wa, wa);
         cycles++;
         if (!ready && rd_data[DW-1:0] !== '0) begin
            checkOutput({tag, "_clear_rd"}, rd_data[DW-1:0], '0);
         end
      end
      checkOutput({tag, "_sweep_len"}, cycles, 32);
   endtask

   initial begin
      logic [DW-1:0] e6;
      reset   = 1'b0;
      wen     = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      @(posedge clock);
      #1;

      // Reset state and clear sweep length
      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, 5'd0);
      reset = 1'b0;
      checkOutput("reset_rd0", rd_data[DW-1:0], '0);
      checkOutput("reset_rd3", rd_data[3*DW +: DW], '0);
      resetAndSweep("init", 1'b0, 5'd0, '0);

      // All 32 registers read back as zero
      for (int base = 0; base < 32; base += 4) begin
         applyStimulus(1'b0, 5'd0, '0, AW'(base), AW'(base + 1), AW'(base + 2), AW'(base + 3));
         for (int k = 0; k < NRD; k++) begin
            checkOutput($sformatf("cleared_r%0d", base + k), rd_data[k*DW +: DW], '0);
         end
      end

      // Directed table in RUN: bypass, multi-port same-address reads, overwrite
      addVec(0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd1,  5'd2,
             32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
      addVec(1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd6,  5'd5,
             32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
      addVec(2, 1'b1, 5'd7,  32'h00001234, 5'd1,  5'd2,  5'd3,  5'd4,
             32'h0, 32'h0, 32'h0, 32'h0);
      addVec(3, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  5'd7,
             32'h00001234, 32'h00001234, 32'h00001234, 32'h00001234);
      addVec(4, 1'b1, 5'd7,  32'h00005678, 5'd7,  5'd7,  5'd5,  5'd31,
             32'h00005678, 32'h00005678, 32'hDEADBEEF, 32'h0);
      addVec(5, 1'b1, 5'd31, 32'hCAFEF00D, 5'd7,  5'd31, 5'd0,  5'd30,
             32'h00005678, 32'hCAFEF00D, 32'h0, 32'h0);
      addVec(6, 1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 5'd7,  5'd5,
             32'hCAFEF00D, 32'h0, 32'h00005678, 32'hDEADBEEF);
      addVec(7, 1'b1, 5'd9,  32'd42,       5'd9,  5'd8,  5'd10, 5'd9,
             32'd42, 32'h0, 32'h0, 32'd42);
      addVec(8, 1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  5'd9,  5'd9,
             32'd42, 32'd42, 32'd42, 32'd42);

      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].wen, vecs[v].wa, vecs[v].wd,
                       vecs[v].ra[0], vecs[v].ra[1], vecs[v].ra[2], vecs[v].ra[3]);
         for (int k = 0; k < NRD; k++) begin
            checkOutput($sformatf("vec%0d_p%0d", v, k), rd_data[k*DW +: DW], vecs[v].exp[k]);
         end
      end

      // Reset pulse 10 cycles into RUN while hammering a write to reg 3 during the sweep
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 5'd0, '0, 5'd9, 5'd0, 5'd0, 5'd0);
      end
      checkOutput("run_ready_high", {31'd0, ready}, 32'd1);
      resetAndSweep("midrun", 1'b1, 5'd3, 32'hFFFFFFFF);
      applyStimulus(1'b0, 5'd0, '0, 5'd3, 5'd9, 5'd5, 5'd7);
      checkOutput("clear_write_dropped_r3", rd_data[0*DW +: DW], '0);
      checkOutput("swept_r9", rd_data[1*DW +: DW], '0);
      checkOutput("swept_r5", rd_data[2*DW +: DW], '0);
      checkOutput("swept_r7", rd_data[3*DW +: DW], '0);

      // Register 0 behaviour: same-cycle bypass read and next-cycle array read
`ifdef MULTIPORT_REGFILE_ZERO_REG_EN
      e6 = 32'h0;
`else
      e6 = 32'hA5A5A5A5;
`endif
      applyStimulus(1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd1, 5'd0);
      checkOutput("r0_same_cycle", rd_data[0*DW +: DW], e6);
      checkOutput("r1_untouched", rd_data[2*DW +: DW], '0);
      applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, 5'd0);
      checkOutput("r0_next_cycle", rd_data[0*DW +: DW], e6);
      checkOutput("r0_next_cycle_p3", rd_data[3*DW +: DW], e6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
